acr_packet_multirate: RTL and testbench

Runtime-configurable successor to the fixed-rate HDMI Audio Clock Regeneration packet source, clocked in the pixel domain.
- Selects N per sample rate at run time (HDMI 1.4b "Other" column, 7 rates).
- Synchronises the audio sample clock and measures CTS in pixel cycles.
- Detects loss of audio clock.
- Hands finished ACR packets to the packet scheduler through a valid/ack handshake.
- Sits beside the audio sample packet path, feeding the data-island packet picker.

---
 rtl/acr_packet_multirate_pkg.sv | 54 +++++
 rtl/acr_packet_multirate_cts_meter.sv | 127 ++++++++++++
 rtl/acr_packet_multirate.sv | 78 +++++++
 tb/tb_acr_packet_multirate.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/acr_packet_multirate_pkg.sv
// Purpose: shared types and helpers for the HDMI ACR packet source (rate codes, N table, packing).
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package hdmi_acr_pkg;

    // Audio sample rate codes as driven on rate_sel.
    typedef enum logic [2:0] {
        RATE_32K   = 3'd0,
        RATE_44K1  = 3'd1,
        RATE_48K   = 3'd2,
        RATE_88K2  = 3'd3,
        RATE_96K   = 3'd4,
        RATE_176K4 = 3'd5,
        RATE_192K  = 3'd6,
        RATE_RSVD  = 3'd7
    } rate_sel_e;

    // CTS meter states.
    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ALIGN    = 2'd1,
        ST_MEASURE  = 2'd2
    } meter_state_e;

    localparam logic [7:0] ACR_PKT_TYPE = 8'd1;

    // N values from the HDMI "Other" pixel clock column; reserved code yields 0.
    function automatic logic [19:0] acr_n_lookup(input logic [2:0] rate);
        case (rate_sel_e'(rate))
            RATE_32K:   return 20'd4096;
            RATE_44K1:  return 20'd6272;
            RATE_48K:   return 20'd6144;
            RATE_88K2:  return 20'd12544;
            RATE_96K:   return 20'd12288;
            RATE_176K4: return 20'd25088;
            RATE_192K:  return 20'd24576;
            default:    return 20'd0;
        endcase
    endfunction

    // Window length in fs edges = N/128. Every table entry is below 2^15,
    // so bits [14:7] hold the whole quotient.
    function automatic logic [7:0] acr_window_len(input logic [19:0] n);
        return n[14:7];
    endfunction

    // One ACR subpacket: N then CTS, each as three little-endian bytes.
    function automatic logic [55:0] acr_pack_sub(input logic [19:0] n,
                                                 input logic [19:0] cts);
        return {n[7:0], n[15:8], 4'd0, n[19:16],
                cts[7:0], cts[15:8], 4'd0, cts[19:16], 8'd0};
    endfunction

endpackage

// File: rtl/acr_packet_multirate_cts_meter.sv
// Purpose: count clk_pixel cycles over N/128 clk_audio rising edges to produce CTS.
// Latency: clk_audio rise acted on SYNC_STAGES+1 cycles later; cts/wrap update on the window-closing edge, strobe one cycle after.
// Backpressure: none; a measurement is always produced, the consumer must keep up or overwrite.
//
// Ports: clk_pixel/reset_n (sync, active-low); clk_audio sampled as data;
//        audio_enable, rate_sel control; rate_q is the registered rate_sel;
//        cts/cts_valid last measurement; wrap toggles per window; meas_strobe
//        pulses for one cycle after each completed window.
module acr_cts_meter
    import hdmi_acr_pkg::*;
#(
    parameter int CTS_WIDTH   = 20,
    parameter int SYNC_STAGES = 2,
    parameter int CTS_TIMEOUT = 2**20-1
) (
    input  logic                 clk_pixel,
    input  logic                 reset_n,
    input  logic                 clk_audio,
    input  logic                 audio_enable,
    input  logic [2:0]           rate_sel,
    output logic [2:0]           rate_q,
    output logic [CTS_WIDTH-1:0] cts,
    output logic                 cts_valid,
    output logic                 wrap,
    output logic                 meas_strobe
);

    localparam logic [CTS_WIDTH-1:0] TIMEOUT_CNT = CTS_WIDTH'(CTS_TIMEOUT);
    localparam logic [CTS_WIDTH-1:0] CYC_ONE     = 1;

    meter_state_e         state_q, state_d;
    logic [SYNC_STAGES-1:0] sync;
    logic                 sync_last;
    logic [CTS_WIDTH-1:0] cyc_cnt;
    logic [7:0]           edge_cnt;
    logic [7:0]           w_last;
    logic                 audio_rise;
    logic                 rate_chg;
    logic                 cnt_clr, cnt_run, win_done, drop_valid;

    assign audio_rise = sync[SYNC_STAGES-1] & ~sync_last;
    assign rate_chg   = (rate_sel != rate_q);
    assign w_last     = acr_window_len(acr_n_lookup(rate_q)) - 8'd1;

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) state_q <= ST_DISABLED;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        cnt_run    = 1'b0;
        win_done   = 1'b0;
        drop_valid = 1'b0;
        // Disable dominates everything, from any state.
        if (!audio_enable || rate_sel == RATE_RSVD) begin
            state_d    = ST_DISABLED;
            cnt_clr    = 1'b1;
            drop_valid = 1'b1;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d = ST_ALIGN;
                    cnt_clr = 1'b1;
                end
                ST_ALIGN: begin
                    // Counters sit at zero so the first edge starts a clean window.
                    cnt_clr    = 1'b1;
                    drop_valid = rate_chg;
                    if (!rate_chg && audio_rise) state_d = ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (rate_chg) begin
                        state_d    = ST_ALIGN;
                        drop_valid = 1'b1;
                    end else if (cyc_cnt == TIMEOUT_CNT) begin
                        // Checked before completion so cyc_cnt+1 can never overflow.
                        state_d    = ST_ALIGN;
                        drop_valid = 1'b1;
                    end else if (audio_rise && edge_cnt == w_last) begin
                        win_done = 1'b1;
                        cnt_clr  = 1'b1;
                    end else begin
                        cnt_run = 1'b1;
                    end
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            sync        <= '0;
            sync_last   <= 1'b0;
            rate_q      <= RATE_RSVD;
            cyc_cnt     <= '0;
            edge_cnt    <= '0;
            cts         <= '0;
            cts_valid   <= 1'b0;
            wrap        <= 1'b0;
            meas_strobe <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], clk_audio};
            sync_last   <= sync[SYNC_STAGES-1];
            rate_q      <= rate_sel;
            meas_strobe <= win_done;
            if (cnt_clr) begin
                cyc_cnt  <= '0;
                edge_cnt <= '0;
            end else if (cnt_run) begin
                cyc_cnt <= cyc_cnt + CYC_ONE;
                if (audio_rise) edge_cnt <= edge_cnt + 8'd1;
            end
            // The closing edge itself is one more cycle, hence the +1.
            if (win_done) begin
                cts       <= cyc_cnt + CYC_ONE;
                wrap      <= ~wrap;
                cts_valid <= 1'b1;
            end else if (drop_valid) begin
                cts_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/acr_packet_multirate.sv
// Purpose: HDMI Audio Clock Regeneration packet source with run-time selectable sample rate.
// Latency: packet_valid rises two cycles after the window-closing audio edge is acted on.
// Backpressure: valid/ack; an unacked packet is overwritten by the next measurement and overrun latches.
//
// Ports: clk_pixel/reset_n (sync, active-low); clk_audio async fs sampled as data;
//        audio_enable, rate_sel configuration; packet_valid/packet_ack handshake;
//        header/sub packet contents; cts, n_value, cts_valid, overrun,
//        clk_audio_counter_wrap status.
module acr_packet_multirate
    import hdmi_acr_pkg::*;
#(
    parameter int CTS_WIDTH   = 20,
    parameter int SYNC_STAGES = 2,
    parameter int CTS_TIMEOUT = 2**20-1
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic             clk_audio,
    input  logic             audio_enable,
    input  logic [2:0]       rate_sel,
    input  logic             packet_ack,
    output logic             packet_valid,
    output logic [23:0]      header,
    output logic [3:0][55:0] sub,
    output logic [19:0]      cts,
    output logic [19:0]      n_value,
    output logic             cts_valid,
    output logic             overrun,
    output logic             clk_audio_counter_wrap
);

    logic [2:0]           rate_q;
    logic [CTS_WIDTH-1:0] meas_cts;
    logic                 meas_strobe;
    logic [19:0]          pkt_n;
    logic [19:0]          pkt_cts;

    acr_cts_meter #(
        .CTS_WIDTH   (CTS_WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .CTS_TIMEOUT (CTS_TIMEOUT)
    ) u_meter (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .clk_audio    (clk_audio),
        .audio_enable (audio_enable),
        .rate_sel     (rate_sel),
        .rate_q       (rate_q),
        .cts          (meas_cts),
        .cts_valid    (cts_valid),
        .wrap         (clk_audio_counter_wrap),
        .meas_strobe  (meas_strobe)
    );

    assign n_value = acr_n_lookup(rate_q);
    assign cts     = 20'(meas_cts);
    assign header  = {8'd0, 8'd0, ACR_PKT_TYPE};
    assign sub     = {4{acr_pack_sub(pkt_n, pkt_cts)}};

    // Shadow register: only a strobe changes the contents, so header/sub are
    // stable while a packet is pending. The latest measurement always wins.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            packet_valid <= 1'b0;
            overrun      <= 1'b0;
            pkt_n        <= '0;
            pkt_cts      <= '0;
        end else if (meas_strobe) begin
            pkt_n        <= n_value;
            pkt_cts      <= cts;
            packet_valid <= 1'b1;
            if (packet_valid && !packet_ack) overrun <= 1'b1;
        end else if (packet_ack) begin
            packet_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acr_packet_multirate.sv
// Purpose: directed self-checking bench for acr_packet_multirate.
// Latency: n/a.
// Backpressure: bench drives packet_ack directly.
module tb_acr_packet_multirate;

    localparam int CTS_W = 16;
    localparam int TMO   = 1000;

    logic             clk_pixel = 1'b0;
    logic             reset_n;
    logic             clk_audio;
    logic             audio_enable;
    logic [2:0]       rate_sel;
    logic             packet_ack;
    logic             packet_valid;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic [19:0]      cts;
    logic [19:0]      n_value;
    logic             cts_valid;
    logic             overrun;
    logic             clk_audio_counter_wrap;

    bit aud_run = 1'b0;
    int aud_half = 50;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    acr_packet_multirate #(
        .CTS_WIDTH   (CTS_W),
        .SYNC_STAGES (2),
        .CTS_TIMEOUT (TMO)
    ) dut (
        .clk_pixel              (clk_pixel),
        .reset_n                (reset_n),
        .clk_audio              (clk_audio),
        .audio_enable           (audio_enable),
        .rate_sel               (rate_sel),
        .packet_ack             (packet_ack),
        .packet_valid           (packet_valid),
        .header                 (header),
        .sub                    (sub),
        .cts                    (cts),
        .n_value                (n_value),
        .cts_valid              (cts_valid),
        .overrun                (overrun),
        .clk_audio_counter_wrap (clk_audio_counter_wrap)
    );

    always #5 clk_pixel = ~clk_pixel;

    always @(posedge clk_pixel) cyc <= cyc + 1;

    // Audio clock: period 2*aud_half, edges offset 3 units from pixel edges.
    initial begin
        clk_audio = 1'b0;
        #3;
        forever begin
            if (aud_run) begin
                clk_audio = 1'b1;
                #(aud_half);
                clk_audio = 1'b0;
                #(aud_half);
            end else begin
                #10;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_pixel);
    endtask

    task automatic ack_pulse();
        packet_ack = 1'b1;
        @(negedge clk_pixel);
        packet_ack = 1'b0;
    endtask

    // Returns on the negedge right after the next window completes.
    task automatic wait_wrap(input string tag, input int max, output int n);
        logic w0;
        w0 = clk_audio_counter_wrap;
        n  = 0;
        while (clk_audio_counter_wrap === w0 && n < max) begin
            @(negedge clk_pixel);
            n++;
        end
        chk(tag, clk_audio_counter_wrap !== w0, 1);
    endtask

    localparam logic [55:0] SUB_48K = 56'h001800E0010000;   // N=6144, CTS=480
    localparam logic [55:0] SUB_44K = 56'h8018004C020000;   // N=6272, CTS=588

    initial begin
        int n, t1, t2;
        reset_n = 1'b0; audio_enable = 1'b0; rate_sel = 3'd7; packet_ack = 1'b0;
        step(3);
        chk("rst_pkt_valid", packet_valid, 0);
        chk("rst_cts", cts, 0);
        chk("rst_cts_valid", cts_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_wrap", clk_audio_counter_wrap, 0);
        chk("rst_n_value", n_value, 0);
        chk("header", header, 24'h000001);
        chk("rst_sub", sub[0], 0);

        // 48k, clk_audio period 10 pixel cycles: CTS = 10*48 = 480.
        rate_sel = 3'd2; audio_enable = 1'b1; reset_n = 1'b1; aud_run = 1'b1;
        step(2);
        chk("n_48k", n_value, 20'd6144);
        chk("cts_valid_align", cts_valid, 0);
        wait_wrap("win1_done", 1000, n);
        t1 = cyc;
        chk("first_window_lat", (n >= 480 && n <= 500), 1);
        chk("cts_48k", cts, 20'd480);
        chk("cts_valid_48k", cts_valid, 1);
        chk("wrap_1", clk_audio_counter_wrap, 1);
        chk("pkt_load_latency", packet_valid, 0);
        step(1);
        chk("pkt_valid_1", packet_valid, 1);
        chk("sub0_48k", sub[0], SUB_48K);
        chk("sub3_48k", sub[3], SUB_48K);
        ack_pulse();
        chk("ack_clears", packet_valid, 0);
        chk("no_overrun", overrun, 0);

        wait_wrap("win2_done", 1000, n);
        t2 = cyc;
        chk("window_period", t2 - t1, 480);
        chk("wrap_0", clk_audio_counter_wrap, 0);
        packet_ack = 1'b1;
        step(1);
        packet_ack = 1'b0;
        chk("load_with_stray_ack", packet_valid, 1);
        chk("no_overrun_2", overrun, 0);

        wait_wrap("win3_done", 1000, n);
        step(1);
        chk("overrun_set", overrun, 1);
        chk("overrun_valid", packet_valid, 1);
        chk("overrun_sub", sub[0], SUB_48K);

        wait_wrap("win4_done", 1000, n);
        packet_ack = 1'b1;
        step(1);
        packet_ack = 1'b0;
        chk("ack_on_load_keeps_valid", packet_valid, 1);
        chk("overrun_sticky", overrun, 1);
        ack_pulse();
        chk("ack_clears_2", packet_valid, 0);

        // Mid-window switch to 44.1k with period 12: CTS = 12*49 = 588.
        step(200);
        @(posedge clk_audio);
        step(4);
        rate_sel = 3'd1; aud_half = 60;
        step(1);
        chk("rate_chg_drops_valid", cts_valid, 0);
        chk("n_44k", n_value, 20'd6272);
        chk("cts_held", cts, 20'd480);
        wait_wrap("win_44k_done", 2000, n);
        chk("no_partial_pkt", packet_valid, 0);
        chk("cts_44k", cts, 20'd588);
        step(1);
        chk("pkt_valid_44k", packet_valid, 1);
        chk("sub0_44k", sub[0], SUB_44K);
        ack_pulse();

        // Stop the audio clock: timeout after TMO cycles drops cts_valid.
        aud_run = 1'b0;
        step(500);
        chk("before_timeout", cts_valid, 1);
        step(600);
        chk("after_timeout", cts_valid, 0);
        chk("timeout_no_pkt", packet_valid, 0);
        aud_run = 1'b1;
        wait_wrap("win_restart", 2000, n);
        chk("restart_lat", (n >= 588 && n <= 620), 1);
        chk("cts_restart", cts, 20'd588);
        step(1);
        chk("pkt_restart", packet_valid, 1);

        // Reset with a packet pending, released while clk_audio is low.
        step(100);
        @(negedge clk_audio);
        step(1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        chk("mid_rst_pkt_valid", packet_valid, 0);
        chk("mid_rst_cts", cts, 0);
        chk("mid_rst_cts_valid", cts_valid, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_sub", sub[0], 0);
        wait_wrap("win_after_rst", 2000, n);
        chk("after_rst_lat", (n >= 588 && n <= 625), 1);
        chk("after_rst_no_early_pkt", packet_valid, 0);
        chk("cts_after_rst", cts, 20'd588);
        step(1);
        chk("pkt_after_rst", packet_valid, 1);

        // Reserved rate: disabled, pending packet held until acked.
        rate_sel = 3'd7;
        step(2);
        chk("n_rsvd", n_value, 0);
        chk("cts_valid_rsvd", cts_valid, 0);
        step(1500);
        chk("no_wrap_rsvd", clk_audio_counter_wrap, 1);
        chk("pending_kept", packet_valid, 1);
        ack_pulse();
        chk("ack_in_disabled", packet_valid, 0);

        rate_sel = 3'd1; audio_enable = 1'b0;
        step(800);
        chk("no_wrap_disabled", clk_audio_counter_wrap, 1);
        chk("cts_valid_disabled", cts_valid, 0);
        chk("no_pkt_disabled", packet_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
